dff_elastic_pipe: RTL and testbench
===================================

// Module: dff_elastic_pipe
// PURPOSE
//   Parametrised elastic register pipeline: DEPTH stages of WIDTH-bit flops, each with a valid bit.
//   Upstream and downstream use valid/ready. Bubbles collapse, so a stage loads whenever it is empty or draining.
//   Next generation of the single D flip-flop: adds width, depth, back-pressure, flush and occupancy.
//   Sits between any two valid/ready blocks as a retiming/buffer slice.
// PARAMETERS
//   WIDTH      8    data width in bits (>=1)
//   DEPTH      4    number of register stages (>=1)
//   RESET_VAL  0    value loaded into every stage data register on rst (WIDTH bits)
// PORTS
//   clk        in   1                    rising-edge clock
//   rst        in   1                    synchronous reset, active-high
//   flush      in   1                    sync clear of all stage valids (data regs untouched)
//   in_valid   in   1                    upstream data valid
//   in_data    in   WIDTH                upstream data
//   in_ready   out  1                    pipe can accept in_data this cycle
//   out_valid  out  1                    last stage holds valid data
//   out_data   out  WIDTH                last stage data
//   out_ready  in   1                    downstream accepts out_data this cycle
//   occupancy  out  $clog2(DEPTH+1)      number of valid stages, 0..DEPTH
// BEHAVIOUR
//   - Reset is synchronous and active-high on clk: all v[i]=0, all d[i]=RESET_VAL, occupancy=0.
//     Hence out_valid=0, out_data=RESET_VAL, in_ready=1 in the cycle after rst.
//   - Stages 0..DEPTH-1. Stage 0 takes in_data. Stage DEPTH-1 drives out_*.
//   - Combinational chain, evaluated from the output end:
//       mv[DEPTH-1] = v[DEPTH-1] & out_ready
//       en[i]       = ~v[i] | mv[i]
//       mv[i]       = v[i] & en[i+1]           (i < DEPTH-1)
//     in_ready = en[0] & ~flush.   in_fire = in_valid & in_ready.
//   - On the clock edge, when neither rst nor flush is active:
//       stage 0: if en[0], d[0] <= in_data and v[0] <= in_fire.
//       stage i>0: if en[i], d[i] <= d[i-1] and v[i] <= mv[i-1].
//       Data regs load only when en[i]=1. Bubble loads may overwrite data but never set valid.
//   - Latency: into an empty pipe, an item accepted at edge N is presented on out_valid/out_data after edge N+DEPTH-1.
//     It therefore becomes visible DEPTH-1 cycles after the accepting cycle. With DEPTH=1 it is visible the cycle after acceptance.
//   - Throughput: 1 item/cycle sustained when out_ready=1. No bubbles are inserted.
//   - Full (all v=1) with out_ready=0: in_ready=0 and every stage holds. out_data stays stable while out_valid=1 and out_ready=0.
//   - Full with out_ready=1: the whole pipe shifts and in_ready=1 in the same cycle (simultaneous push and pop).
//   - Ordering is strict FIFO. No item is dropped or duplicated except by flush or rst.
//   - flush=1: every v[i] <= 0 next edge and in_ready=0, so the input is not accepted. Data regs are unchanged.
//     An out handshake in the flush cycle still counts as a completed transfer.
//   - rst has priority over flush. rst mid-stream discards all items; nothing is emitted afterward.
//   - occupancy is registered and equals popcount(v) after every edge.
//     It changes by +1 (push only), -1 (pop only) or 0 (both or neither), and becomes 0 after flush or rst.
//   - out_valid must never depend combinationally on out_ready. in_ready may depend on out_ready (ready chain).
// TESTING
//   1 Reset: drive rst=1 for 2 cycles with in_valid=1, in_data=8'hAA
//     -> out_valid=0, out_data=8'h00, occupancy=0, and no item appears later.
//   2 Latency (DEPTH=4, out_ready=1): push 8'h11 once into an empty pipe
//     -> out_valid=1 with 8'h11 exactly 3 cycles after the accepting cycle, for 1 cycle only.
//   3 Streaming: push 8'h01..8'h10 back-to-back with out_ready=1
//     -> outputs 01..10 in order on consecutive cycles, and in_ready stays 1 throughout.
//   4 Back-pressure: out_ready=0 and push until in_ready=0
//     -> exactly 4 items accepted and occupancy=4. Raise out_ready -> 4 items drain in order, with in_ready=1 in the first drain cycle.
//   5 Bubble collapse: push A, idle 2 cycles, push B, with out_ready=0
//     -> both items are packed in stages 3 and 2, and occupancy=2.
//   6 Flush: pipe holds 3 items and flush=1 with in_valid=1, in_data=8'h55
//     -> next cycle occupancy=0 and out_valid=0, 8'h55 never emitted. With rst=1 and flush=1 together -> reset values.

Source files
------------

// File: rtl/dff_elastic_pipe.sv
// Elastic register pipeline: DEPTH valid-tagged stages with a collapsing ready chain,
// flush of all valids, and a registered occupancy count.
module dff_elastic_pipe #(
  parameter int unsigned       WIDTH     = 8,
  parameter int unsigned       DEPTH     = 4,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  input  logic [WIDTH-1:0]               in_data,
  output logic                           in_ready,
  output logic                           out_valid,
  output logic [WIDTH-1:0]               out_data,
  input  logic                           out_ready,
  output logic [$clog2(DEPTH+1)-1:0]     occupancy
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] en;
  logic [DEPTH-1:0] mv;
  logic [WIDTH-1:0] d [DEPTH];
  logic             in_fire;
  logic             out_fire;

  // Ready chain resolved from the output end so a draining tail frees every stage behind it
  always_comb begin
    en = '0;
    mv = '0;
    mv[DEPTH-1] = v[DEPTH-1] & out_ready;
    en[DEPTH-1] = ~v[DEPTH-1] | mv[DEPTH-1];
    for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
      mv[i] = v[i] & en[i+1];
      en[i] = ~v[i] | mv[i];
    end
  end

  assign in_ready  = en[0] & ~flush;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = mv[DEPTH-1];
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      v         <= '0;
      occupancy <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        d[i] <= RESET_VAL;
      end
    end else if (flush) begin
      // Data registers are left as-is; only the valid tags are dropped
      v         <= '0;
      occupancy <= '0;
    end else begin
      if (en[0]) begin
        d[0] <= in_data;
        v[0] <= in_fire;
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
        if (en[i]) begin
          d[i] <= d[i-1];
          v[i] <= mv[i-1];
        end
      end
      occupancy <= occupancy + OCC_W'(in_fire) - OCC_W'(out_fire);
    end
  end

endmodule

// File: tb/tb_dff_elastic_pipe.sv
// Bench for dff_elastic_pipe: directed scenarios plus random traffic, checked against
// an item-level model where each queued item tracks the stage it has reached.
module tb_dff_elastic_pipe;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [OCC_W-1:0] occupancy;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: md = data of queued items (head first), mp = stage each item sits in
  int md[$];
  int mp[$];
  int nd[$];
  int np_q[$];
  bit exp_ir;
  logic ir_seen;

  always #5 clk = ~clk;

  dff_elastic_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(8'h00)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each item moves one stage forward unless blocked by the item ahead of it
  task automatic model_next();
    int lim;
    bit pop;
    nd     = {};
    np_q   = {};
    exp_ir = 1'b0;
    if (rst || flush) return;
    lim = int'(DEPTH);
    pop = out_ready && (md.size() > 0) && (mp[0] == int'(DEPTH) - 1);
    for (int k = 0; k < md.size(); k++) begin
      int p;
      if (k == 0 && pop) continue;
      p = (mp[k] + 1 < lim - 1) ? mp[k] + 1 : lim - 1;
      nd.push_back(md[k]);
      np_q.push_back(p);
      lim = p;
    end
    exp_ir = (lim >= 1);
    if (in_valid && exp_ir) begin
      nd.push_back(int'(in_data));
      np_q.push_back(0);
    end
  endtask

  function automatic bit model_out_valid();
    return (md.size() > 0) && (mp[0] == int'(DEPTH) - 1);
  endfunction

  task automatic step();
    @(negedge clk);
    model_next();
    ir_seen = in_ready;
    if (!rst) chk("in_ready", 32'(in_ready), 32'(exp_ir));
    @(posedge clk);
    #1;
    md = nd;
    mp = np_q;
    chk("out_valid", 32'(out_valid), 32'(model_out_valid()));
    chk("occupancy", 32'(occupancy), 32'(md.size()));
    if (model_out_valid()) chk("out_data", 32'(out_data), 32'(md[0]));
  endtask

  initial begin
    int acc;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b1;

    // Reset with an active input: nothing may leak through
    step();
    step();
    chk("rst_out_data", 32'(out_data), 32'h00);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();

    // Single-item latency
    in_valid = 1'b1; in_data = 8'h11;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("lat_valid", 32'(out_valid), (k == 3) ? 32'h1 : 32'h0);
      if (k == 3) chk("lat_data", 32'(out_data), 32'h11);
    end

    // Back-to-back streaming
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      step();
      chk("stream_ready", 32'(ir_seen), 32'h1);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();

    // Back-pressure fill and drain
    out_ready = 1'b0; acc = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h20 + i);
      step();
      if (ir_seen !== 1'b1) break;
      acc++;
    end
    chk("bp_accepted", 32'(acc), 32'd4);
    chk("bp_occ", 32'(occupancy), 32'd4);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("drain_ready", 32'(ir_seen), 32'h1);
    for (int i = 0; i < 4; i++) step();

    // Bubble collapse under stall
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hA5; step();
    in_valid = 1'b0; step(); step();
    in_valid = 1'b1; in_data = 8'h5B; step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("bubble_occ", 32'(occupancy), 32'd2);
    chk("bubble_head", 32'(out_data), 32'hA5);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Flush with three items held and a competing input
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h30 + i); step();
    end
    in_valid = 1'b0;
    chk("pre_flush_occ", 32'(occupancy), 32'd3);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    step();
    chk("flush_ready", 32'(ir_seen), 32'h0);
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'h0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();

    // Reset takes priority over flush
    in_valid = 1'b1; in_data = 8'h66; step(); step();
    rst = 1'b1; flush = 1'b1;
    step();
    chk("rstfl_data", 32'(out_data), 32'h00);
    chk("rstfl_occ", 32'(occupancy), 32'd0);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 1500; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 49) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      out_ready = (i % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
